// File: rtl/serdes_unpack.sv
// serdes_unpack: re-slices a dense stream of IN_COUNT operands per word into
// low-justified, zero-padded output words whose operand counts come from a config FIFO.
module serdes_unpack #(
  parameter int IN_COUNT  = 10,
  parameter int OUT_COUNT = 10,
  parameter int OP_WIDTH  = 16,
  parameter int IN_WIDTH  = IN_COUNT * OP_WIDTH,
  parameter int OUT_WIDTH = OUT_COUNT * OP_WIDTH,
  parameter int COUNT_W   = $clog2(OUT_COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COUNT_W-1:0]   cfg_count,
  input  logic                 cfg_push,
  output logic                 cfg_ready,
  input  logic                 s_read_req,
  input  logic                 s_read_last,
  output logic                 s_read_ready,
  input  logic [IN_WIDTH-1:0]  s_read_data,
  output logic                 m_read_req,
  input  logic                 m_read_ready,
  output logic [OUT_WIDTH-1:0] m_read_data,
  output logic [COUNT_W-1:0]   m_read_count
);
  localparam int LEFT_W = $clog2(IN_COUNT + 1);
  localparam logic [LEFT_W-1:0]  IN_FULL = LEFT_W'(IN_COUNT);
  localparam logic [COUNT_W-1:0] OUT_MAX = COUNT_W'(OUT_COUNT);

  typedef enum logic [1:0] {IDLE, RUN, EMIT} state_t;
  state_t state, state_next;

  logic [IN_WIDTH:0]    dq_mem [8];
  logic [2:0]           dq_wr, dq_rd;
  logic [3:0]           dq_cnt;
  logic                 dq_push, dq_pop, dq_pop_ok, dq_empty;
  logic [IN_WIDTH:0]    dq_head;

  logic [COUNT_W-1:0]   cq_mem [32];
  logic [4:0]           cq_wr, cq_rd;
  logic [5:0]           cq_cnt;
  logic                 cq_push, cq_pop, cq_pop_ok, cq_empty;
  logic [COUNT_W-1:0]   target;

  logic [IN_WIDTH-1:0]  in_word;
  logic [LEFT_W-1:0]    in_left;
  logic                 in_last;
  logic [OUT_WIDTH-1:0] acc;
  logic [COUNT_W-1:0]   fill;
  logic                 do_shift, do_drop, do_clear;

  assign s_read_ready = (dq_cnt != 4'd8);
  assign dq_empty     = (dq_cnt == 4'd0);
  assign dq_push      = s_read_req && s_read_ready;
  assign dq_pop_ok    = dq_pop && !dq_empty;
  assign dq_head      = dq_mem[dq_rd];

  assign cfg_ready    = (cq_cnt != 6'd32);
  assign cq_empty     = (cq_cnt == 6'd0);
  assign cq_push      = cfg_push && cfg_ready;
  assign cq_pop_ok    = cq_pop && !cq_empty;
  assign target       = cq_mem[cq_rd];

  // FIFO storage carries no reset; occupancy counters alone define validity
  always_ff @(posedge clk) begin
    if (dq_push) dq_mem[dq_wr] <= {s_read_last, s_read_data};
    if (cq_push) cq_mem[cq_wr] <= cfg_count;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dq_wr  <= '0;
      dq_rd  <= '0;
      dq_cnt <= '0;
      cq_wr  <= '0;
      cq_rd  <= '0;
      cq_cnt <= '0;
    end else begin
      if (dq_push)   dq_wr <= dq_wr + 3'd1;
      if (dq_pop_ok) dq_rd <= dq_rd + 3'd1;
      dq_cnt <= dq_cnt + 4'(dq_push) - 4'(dq_pop_ok);
      if (cq_push)   cq_wr <= cq_wr + 5'd1;
      if (cq_pop_ok) cq_rd <= cq_rd + 5'd1;
      cq_cnt <= cq_cnt + 6'(cq_push) - 6'(cq_pop_ok);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    dq_pop     = 1'b0;
    cq_pop     = 1'b0;
    do_shift   = 1'b0;
    do_drop    = 1'b0;
    do_clear   = 1'b0;
    case (state)
      IDLE: begin
        if (!dq_empty) begin
          dq_pop     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // A zero count is illegal; it is retired without producing a word
        if (cq_empty) begin
          if (in_last) begin
            do_drop    = 1'b1;
            state_next = IDLE;
          end
        end else if (target == '0) begin
          cq_pop = 1'b1;
        end else if (fill == target || fill == OUT_MAX) begin
          state_next = EMIT;
        end else if (in_left != '0) begin
          do_shift = 1'b1;
        end else if (in_last && fill != '0) begin
          state_next = EMIT;
        end else begin
          state_next = IDLE;
        end
      end
      EMIT: begin
        if (m_read_ready) begin
          cq_pop     = 1'b1;
          do_clear   = 1'b1;
          state_next = (in_left != '0) ? RUN : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_word <= '0;
      in_left <= '0;
      in_last <= 1'b0;
      acc     <= '0;
      fill    <= '0;
    end else begin
      if (dq_pop_ok) begin
        in_word <= dq_head[IN_WIDTH-1:0];
        in_last <= dq_head[IN_WIDTH];
        in_left <= IN_FULL;
      end else if (do_shift) begin
        acc     <= acc | (OUT_WIDTH'(in_word[OP_WIDTH-1:0]) << (int'(fill) * OP_WIDTH));
        in_word <= in_word >> OP_WIDTH;
        fill    <= fill + COUNT_W'(1);
        in_left <= in_left - LEFT_W'(1);
      end else if (do_drop) begin
        in_left <= '0;
      end
      if (do_clear) begin
        acc  <= '0;
        fill <= '0;
      end
    end
  end

  assign m_read_req   = (state == EMIT);
  assign m_read_data  = m_read_req ? acc : '0;
  assign m_read_count = m_read_req ? fill : '0;

endmodule
